// File: rtl/ir_cmd_pkg.sv
// Shared types for the IR remote command decoder: drive commands, NEC key codes,
// FSM states and the key-to-command lookup.
package ir_cmd_pkg;

  localparam int unsigned CMD_W = 3;
  localparam int unsigned ERR_W = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_BACK  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4
  } cmd_e;

  localparam logic [7:0] KEY_FWD   = 8'h1A;
  localparam logic [7:0] KEY_BACK  = 8'h1E;
  localparam logic [7:0] KEY_LEFT  = 8'h14;
  localparam logic [7:0] KEY_RIGHT = 8'h18;
  localparam logic [7:0] KEY_STOP  = 8'h0C;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_OFFER  = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]  key_n;
    logic [7:0]  key;
    logic [15:0] custom;
  } nec_frame_t;

  typedef struct packed {
    logic hit;
    cmd_e cmd;
  } key_map_t;

  // Unmapped keys return hit=0 so the decoder can drop them silently.
  function automatic key_map_t map_key(input logic [7:0] key);
    key_map_t m;
    m.hit = 1'b1;
    m.cmd = CMD_STOP;
    case (key)
      KEY_FWD:   m.cmd = CMD_FWD;
      KEY_BACK:  m.cmd = CMD_BACK;
      KEY_LEFT:  m.cmd = CMD_LEFT;
      KEY_RIGHT: m.cmd = CMD_RIGHT;
      KEY_STOP:  m.cmd = CMD_STOP;
      default:   m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ir_hold_timer.sv
// Idle-time counter for the auto-stop feature; saturates at HOLD_CYCLES-1 and
// raises expire while parked there.
module ir_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 12_500_000
) (
  input  logic clk_50,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (clear) begin
      w_count_nxt = '0;
    end else if (enable && (r_count != LAST)) begin
      w_count_nxt = r_count + CNT_W'(1);
    end
  end

  // expire is registered from the next count so it tracks r_count == LAST exactly.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      expire  <= (LAST == '0);
    end else begin
      r_count <= w_count_nxt;
      expire  <= (w_count_nxt == LAST);
    end
  end

endmodule

// File: rtl/ir_command_decoder.sv
// NEC IR frame decoder: validates custom code and key complement, maps keys to
// drive commands and offers them on a valid/ready handshake.
// Optional auto-stop after HOLD_CYCLES idle cycles: define IR_HOLD_TIMEOUT_EN.
module ir_command_decoder
  import ir_cmd_pkg::*;
#(
  parameter logic [15:0] CUSTOM_CODE = 16'h6B86,
  parameter int unsigned HOLD_CYCLES = 12_500_000
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic [31:0]      ir_data,
  input  logic             ir_valid,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count
);

  state_e     r_state, w_state_nxt;
  nec_frame_t r_frame;
  cmd_e       r_cmd, w_cmd_nxt;
  logic       r_cmd_valid, w_cmd_valid_nxt;
  logic       r_frame_err, w_frame_err_nxt;
  logic [ERR_W-1:0] r_err_count;
  logic       w_err_inc;
  logic       w_transfer;
  logic       w_capture;
  logic       w_check_ok;
  logic       w_auto_stop;
  key_map_t   w_map;

  assign w_transfer = r_cmd_valid && cmd_ready;
  assign w_capture  = (r_state == S_IDLE) && ir_valid;
  assign w_check_ok = (r_frame.custom == CUSTOM_CODE) && (r_frame.key == ~r_frame.key_n);
  assign w_map      = map_key(r_frame.key);

`ifdef IR_HOLD_TIMEOUT_EN
  logic w_expire;

  // r_cmd in S_IDLE is always the last transferred command.
  ir_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk_50 (clk_50),
    .reset  (reset),
    .clear  (w_transfer || w_capture),
    .enable (r_state == S_IDLE),
    .expire (w_expire)
  );
  assign w_auto_stop = w_expire && (r_cmd != CMD_STOP);
`else
  // Auto-stop compiled out; HOLD_CYCLES stays so both builds share one parameter list.
  assign w_auto_stop = 1'b0 & (HOLD_CYCLES != 0);
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_nxt       = r_cmd;
    w_cmd_valid_nxt = r_cmd_valid;
    w_frame_err_nxt = 1'b0;
    w_err_inc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ir_valid) begin
          w_state_nxt = S_DECODE;
        end else if (w_auto_stop) begin
          w_state_nxt     = S_OFFER;
          w_cmd_nxt       = CMD_STOP;
          w_cmd_valid_nxt = 1'b1;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_IDLE;
        if (!w_check_ok) begin
          w_frame_err_nxt = 1'b1;
          w_err_inc       = 1'b1;
        end else if (w_map.hit) begin
          w_state_nxt     = S_OFFER;
          w_cmd_nxt       = w_map.cmd;
          w_cmd_valid_nxt = 1'b1;
        end
      end
      S_OFFER: begin
        if (w_transfer) begin
          w_state_nxt     = S_IDLE;
          w_cmd_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_cmd_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_frame     <= '0;
      r_cmd       <= CMD_STOP;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      if (w_capture) begin
        r_frame <= ir_data;
      end
      if (w_err_inc && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign frame_err = r_frame_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_ir_command_decoder.sv
// Self-checking bench for ir_command_decoder: per-cycle compare against a
// transaction-level model, directed scenarios and randomized frames.
module tb_ir_command_decoder;

  localparam int unsigned HOLD = 100;
  localparam logic [15:0] CUST = 16'h6B86;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic [31:0] ir_data;
  logic        ir_valid;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        frame_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  // Key table: the drive command code is the entry's position in this list.
  logic [7:0] key_tab [5] = '{8'h0C, 8'h1A, 8'h1E, 8'h14, 8'h18};

  // Expected outputs for the cycle currently visible, plus pending-work bookkeeping.
  bit          m_valid;
  logic [2:0]  m_cmd;
  bit          m_err;
  int          m_cnt;
  bit          m_pend;
  logic [31:0] m_frame;
  logic [2:0]  m_last;
  int          m_idle;

  ir_command_decoder #(.CUSTOM_CODE(CUST), .HOLD_CYCLES(HOLD)) dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .ir_data   (ir_data),
    .ir_valid  (ir_valid),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lookup(input logic [7:0] key, output logic [2:0] c);
    c = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (key_tab[i] == key) begin
        c = 3'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cmd = 3'd0; m_err = 0; m_cnt = 0;
    m_pend = 0; m_frame = '0; m_last = 3'd0; m_idle = 0;
  endtask

  // Advance the model by one clock given the inputs presented during this cycle.
  task automatic model_step(input bit v, input logic [31:0] d, input bit rdy);
    logic [2:0] c;
    bit ok;
    m_err = 0;
    if (m_valid) begin
      if (rdy) begin
        m_valid = 0;
        m_last  = m_cmd;
        m_idle  = 0;
      end
    end else if (m_pend) begin
      m_pend = 0;
      ok = (m_frame[15:0] == CUST) && (m_frame[23:16] == ~m_frame[31:24]);
      if (!ok) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end else if (lookup(m_frame[23:16], c)) begin
        m_valid = 1;
        m_cmd   = c;
      end
    end else if (v) begin
      m_pend  = 1;
      m_frame = d;
      m_idle  = 0;
    end else begin
`ifdef IR_HOLD_TIMEOUT_EN
      if (m_idle == int'(HOLD) - 1) begin
        if (m_last != 3'd0) begin
          m_valid = 1;
          m_cmd   = 3'd0;
        end
      end else begin
        m_idle++;
      end
`endif
    end
  endtask

  task automatic compare_all();
    chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    chk("cmd", 32'(cmd), 32'(m_cmd));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  // One clock: check the visible cycle, drive this cycle's inputs, predict the next.
  task automatic cycle(input bit v, input logic [31:0] d, input bit rdy);
    compare_all();
    ir_valid  = v;
    ir_data   = d;
    cmd_ready = rdy;
    model_step(v, d, rdy);
    @(negedge clk_50);
  endtask

  function automatic logic [31:0] rand_frame();
    logic [7:0] key;
    logic [7:0] kn;
    logic [15:0] cu;
    int kind;
    kind = int'($urandom_range(0, 3));
    key  = key_tab[$urandom_range(0, 4)];
    cu   = CUST;
    if (kind == 1) key = 8'h50 | 8'($urandom_range(0, 15));
    kn = ~key;
    if (kind == 2) kn = kn ^ (8'h01 << $urandom_range(0, 7));
    if (kind == 3) cu = CUST ^ 16'($urandom_range(1, 65535));
    return {kn, key, cu};
  endfunction

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] d;
    reset = 1'b1; ir_valid = 1'b0; ir_data = '0; cmd_ready = 1'b0;
    model_reset();
    @(negedge clk_50);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    @(negedge clk_50);
    reset = 1'b0;
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_count", 32'(err_count), 32'd0);
    cycle(0, '0, 1);

    // Forward key with ready high: offer two cycles later, for one cycle.
    cycle(1, 32'hE51A6B86, 1);
    chk("fwd_lat1_valid", 32'(cmd_valid), 32'd0);
    cycle(0, '0, 1);
    chk("fwd_valid", 32'(cmd_valid), 32'd1);
    chk("fwd_cmd", 32'(cmd), 32'd1);
    cycle(0, '0, 1);
    chk("fwd_valid_drop", 32'(cmd_valid), 32'd0);
    chk("fwd_cmd_hold", 32'(cmd), 32'd1);

    // Bad complement.
    cycle(1, 32'hE41A6B86, 1);
    cycle(0, '0, 1);
    chk("badcpl_err", 32'(frame_err), 32'd1);
    chk("badcpl_count", 32'(err_count), 32'd1);
    chk("badcpl_valid", 32'(cmd_valid), 32'd0);
    cycle(0, '0, 1);
    chk("badcpl_err_pulse", 32'(frame_err), 32'd0);

    // Backpressure on LEFT; a FWD frame during the stall is dropped.
    cycle(1, 32'hEB146B86, 0);
    cycle(0, '0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(cmd_valid), 32'd1);
      chk("bp_cmd", 32'(cmd), 32'd3);
      cycle(i == 3, 32'hE51A6B86, 0);
    end
    cycle(0, '0, 1);
    chk("bp_done_valid", 32'(cmd_valid), 32'd0);
    chk("bp_done_cmd", 32'(cmd), 32'd3);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1);
    chk("bp_drop_valid", 32'(cmd_valid), 32'd0);
    chk("bp_drop_count", 32'(err_count), 32'd1);

    // Saturation with wrong custom code.
    for (int i = 0; i < 300; i++) begin
      cycle(1, 32'hE51A1234, 1);
      cycle(0, '0, 1);
    end
    cycle(0, '0, 1);
    chk("sat_count", 32'(err_count), 32'hFF);

    // Hold timeout behaviour after a FWD transfer.
    cycle(1, 32'hE51A6B86, 1);
    cycle(0, '0, 1);
    cycle(0, '0, 1);
    chk("to_fwd_done", 32'(cmd_valid), 32'd0);
    n = 0;
`ifdef IR_HOLD_TIMEOUT_EN
    while (cmd_valid !== 1'b1 && n < 300) begin
      cycle(0, '0, 1);
      n++;
    end
    chk("to_gap", 32'(n), 32'(HOLD));
    chk("to_stop_cmd", 32'(cmd), 32'd0);
    for (int i = 0; i < 150; i++) cycle(0, '0, 1);
    chk("to_stop_last_quiet", 32'(cmd_valid), 32'd0);
`else
    for (int i = 0; i < 150; i++) cycle(0, '0, 1);
    chk("to_none_valid", 32'(cmd_valid), 32'd0);
    chk("to_none_cmd", 32'(cmd), 32'd1);
`endif

    // Reset during an offer abandons it immediately.
    cycle(1, 32'hE7186B86, 0);
    cycle(0, '0, 0);
    chk("rstoff_pre_valid", 32'(cmd_valid), 32'd1);
    chk("rstoff_pre_cmd", 32'(cmd), 32'd4);
    cmd_ready = 1'b1;
    #3 reset = 1'b1;
    #1;
    chk("rstoff_valid", 32'(cmd_valid), 32'd0);
    chk("rstoff_cmd", 32'(cmd), 32'd0);
    chk("rstoff_count", 32'(err_count), 32'd0);
    model_reset();
    @(negedge clk_50);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle(0, '0, 1);

    // Randomized traffic with idle gaps long enough for timeouts.
    for (int i = 0; i < 4000; i++) begin
      bit v;
      v = ((i % 1000) < 700) && ($urandom_range(0, 3) == 0);
      d = rand_frame();
      cycle(v, d, ($urandom_range(0, 2) != 0));
    end
    cycle(0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_command_decoder.md
IR_COMMAND_DECODER -- requirements
Module: ir_command_decoder

Interface
REQ-001 Parameter CUSTOM_CODE, default 16'h6B86: remote custom code accepted in ir_data[15:0].
REQ-002 Parameter HOLD_CYCLES, default 12_500_000: auto-stop timeout in clk_50 cycles (250 ms).
REQ-003 clk_50  input  1: system clock, 50 MHz; all logic on rising edge.
REQ-004 reset  input  1: reset, asynchronous, active-high.
REQ-005 ir_data  input  32: NEC frame from the IR receiver; [31:24] inverted key, [23:16] key, [15:0] custom code.
REQ-006 ir_valid  input  1: one-cycle strobe; ir_data valid in the same cycle.
REQ-007 cmd  output  3: drive command to the drive logic.
REQ-008 cmd_valid  output  1: cmd offered; held until accepted.
REQ-009 cmd_ready  input  1: downstream accepts cmd when high together with cmd_valid.
REQ-010 frame_err  output  1: one-cycle pulse when a frame fails the integrity check.
REQ-011 err_count  output  8: count of failed frames, saturating.

Function
REQ-012 FSM states: S_IDLE, S_DECODE, S_OFFER.
REQ-013 S_IDLE + ir_valid: capture ir_data into a frame register and go to S_DECODE.
REQ-014 S_DECODE: check custom code == CUSTOM_CODE and key == ~inverted key.
REQ-015 Check failure: pulse frame_err, increment err_count (saturate at 8'hFF), return to S_IDLE.
REQ-016 Check pass, key mapped: key maps to cmd via package table (0x1A FWD, 0x1E BACK, 0x14 LEFT, 0x18 RIGHT, 0x0C STOP); go to S_OFFER.
REQ-017 Check pass, key unmapped: return to S_IDLE silently; no error, no output.
REQ-018 Latency: ir_valid in cycle N gives cmd_valid high in cycle N+2.
REQ-019 S_OFFER: cmd_valid=1, cmd stable; on cmd_valid&&cmd_ready, transfer, return to S_IDLE, cmd_valid low next cycle.
REQ-020 cmd holds its last transferred value while cmd_valid is low.
REQ-021 ir_valid in S_DECODE or S_OFFER: frame dropped; no error, no count.
REQ-022 cmd_ready while cmd_valid is low: ignored.

Reset
REQ-023 On reset: state S_IDLE, cmd=STOP (3'd0), cmd_valid=0, frame_err=0, err_count=0, hold counter=0.
REQ-024 Reset mid-offer abandons the pending command; no transfer occurs.

Configuration
REQ-025 Macro IR_HOLD_TIMEOUT_EN defined: hold counter clears on every transfer and counts in S_IDLE. At HOLD_CYCLES-1, if the last transferred cmd != STOP, the FSM enters S_OFFER with cmd=STOP.
REQ-026 Timeout boundary: ir_valid in the same cycle as expiry takes priority; the frame is decoded and the counter clears.
REQ-027 Macro IR_HOLD_TIMEOUT_EN undefined: no counter and no auto-stop; a command persists until the next key.

Structure
REQ-028 Package ir_cmd_pkg holds: command typedef (STOP=0, FWD=1, BACK=2, LEFT=3, RIGHT=4), key-code constants, FSM state typedef.
REQ-029 Sub-module ir_hold_timer holds the timeout counter (inputs clear, enable; output expire). It is instantiated only under IR_HOLD_TIMEOUT_EN.

Verification
REQ-030 Forward key, ready tied high: ir_data=32'hE51A6B86 pulse -> cmd=1, cmd_valid high exactly 2 cycles later for 1 cycle.
REQ-031 Bad complement: ir_data=32'hE41A6B86 -> frame_err pulse, err_count=1, cmd_valid stays 0.
REQ-032 Backpressure: cmd_ready=0 for 10 cycles after a valid LEFT frame -> cmd_valid held, cmd=3 stable; second frame during the stall is dropped; transfer on the first ready cycle.
REQ-033 Saturation: 300 frames with wrong custom code -> err_count=8'hFF.
REQ-034 Timeout, macro on, HOLD_CYCLES=100: FWD transferred, no further frames -> STOP offered 100 cycles later. A STOP-last state gives no further offer.
REQ-035 Reset asserted while in S_OFFER -> cmd_valid=0, cmd=0 immediately (asynchronous); no transfer.
